// File: rtl/pipelined_adder.sv
// pipelined_adder: CHUNK-bit sliced pipelined add/subtract with flags and valid/ready backpressure
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int STAGES = WIDTH / CHUNK;
  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int W = WIDTH - k * CHUNK;
    localparam int R = (k + 1) * CHUNK;
    logic [W-1:0]   a_i, b_i;
    logic           c_i, v_i;
    logic [R-1:0]   r_n;
    logic [CHUNK:0] s;
    if (k == 0) begin : g_src
      assign a_i = input1;
      assign b_i = sub ? ~input2 : input2;
      assign c_i = sub;
      assign v_i = in_valid;
      assign r_n = s[CHUNK-1:0];
    end else begin : g_src
      assign a_i = g_st[k-1].g_pipe.a_q;
      assign b_i = g_st[k-1].g_pipe.b_q;
      assign c_i = g_st[k-1].g_pipe.c_q;
      assign v_i = g_st[k-1].g_pipe.v_q;
      assign r_n = {s[CHUNK-1:0], g_st[k-1].g_pipe.r_q};
    end
    assign s = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};
    if (k < STAGES - 1) begin : g_pipe
      logic [W-CHUNK-1:0] a_q, b_q;
      logic [R-1:0]       r_q;
      logic               c_q, v_q;
      // intermediate stage: keep finished low slices, the carry and the unprocessed operand bits
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
        end else if (advance) begin
          v_q <= v_i;
          c_q <= s[CHUNK];
          a_q <= a_i[W-1:CHUNK];
          b_q <= b_i[W-1:CHUNK];
          r_q <= r_n;
        end
    end else begin : g_last
      // final stage: register the full result together with its flags
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          out_valid <= 1'b0;
          out       <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
        end else if (advance) begin
          out_valid <= v_i;
          out       <= r_n;
          carry_out <= s[CHUNK];
          overflow  <= (a_i[CHUNK-1] == b_i[CHUNK-1]) && (s[CHUNK-1] != a_i[CHUNK-1]);
          zero      <= ~|r_n;
        end
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of latency, flags, backpressure and reset for pipelined_adder
module tb_pipelined_adder;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic iv32 = 1'b0, s32 = 1'b0, or32 = 1'b1, ir32, ov32, c32, f32, z32;
  logic [31:0] a32 = '0, b32 = '0, o32;
  logic iv16 = 1'b0, s16 = 1'b0, or16 = 1'b1, ir16, ov16, c16, f16, z16;
  logic [15:0] a16 = '0, b16 = '0, o16;
  logic iv8 = 1'b0, s8 = 1'b0, or8 = 1'b1, ir8, ov8, c8, f8, z8;
  logic [7:0] a8 = '0, b8 = '0, o8;

  pipelined_adder dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .input1(a32), .input2(b32),
    .sub(s32), .out_valid(ov32), .out_ready(or32), .out(o32), .carry_out(c32),
    .overflow(f32), .zero(z32));
  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .input1(a16), .input2(b16),
    .sub(s16), .out_valid(ov16), .out_ready(or16), .out(o16), .carry_out(c16),
    .overflow(f16), .zero(z16));
  pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .input1(a8), .input2(b8),
    .sub(s8), .out_valid(ov8), .out_ready(or8), .out(o8), .carry_out(c8),
    .overflow(f8), .zero(z8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] eo, input logic [2:0] ef);
    int n;
    or32 = 1'b1;
    iv32 = 1'b1; a32 = a; b32 = b; s32 = s;
    #1;
    chk({tag, " in_ready"}, ir32, 1);
    tick;
    n = 1;
    iv32 = 1'b0; a32 = 'x; b32 = 'x;
    while (!ov32 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " out"}, o32, eo);
    chk({tag, " c/ovf/zero"}, {c32, f32, z32}, ef);
    tick;
  endtask

  initial begin
    int n, sent, got, first, stale;
    logic [31:0] held;
    logic acc;
    #1 reset = 1'b1;
    #1;
    chk("reset out_valid32", ov32, 0);
    chk("reset out32", o32, 0);
    chk("reset flags32", {c32, f32, z32}, 0);
    chk("reset out_valid16", ov16, 0);
    chk("reset out_valid8", ov8, 0);
    tick;
    tick;
    reset = 1'b0;
    tick;
    op32("0+0", 32'd0, 32'd0, 1'b0, 32'd0, 3'b001);
    op32("0+10", 32'd0, 32'd10, 1'b0, 32'd10, 3'b000);
    op32("1000+10", 32'd1000, 32'd10, 1'b0, 32'd1010, 3'b000);
    op32("10-1000", 32'd10, 32'd1000, 1'b1, 32'hFFFFFC22, 3'b000);
    op32("1000-10", 32'd1000, 32'd10, 1'b1, 32'd990, 3'b100);
    op32("5-5", 32'd5, 32'd5, 1'b1, 32'd0, 3'b101);
    op32("7FFFFFFF+1", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 3'b010);
    op32("FFFFFFFF+1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 3'b101);
    op32("FF+1", 32'h000000FF, 32'd1, 1'b0, 32'h00000100, 3'b000);
    // backpressure: six back-to-back adds, consumer stalls 3 cycles after first result
    sent = 0; got = 0; first = -1; held = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (ov32 && first < 0) first = cyc;
      or32 = !(first >= 0 && cyc < first + 3);
      iv32 = sent < 6; a32 = 32'(sent + 1); b32 = 32'(sent + 1); s32 = 1'b0;
      #1;
      if (!or32) begin
        chk("bp in_ready low", ir32, 0);
        if (cyc > first) chk("bp out stable", o32, held);
      end
      if (ov32 && or32) begin
        chk("bp result order", o32, 64'(2 * (got + 1)));
        got++;
      end
      held = o32;
      acc = iv32 && ir32;
      tick;
      if (acc) sent++;
    end
    iv32 = 1'b0; or32 = 1'b1;
    chk("bp results", got, 6);
    chk("bp inputs", sent, 6);
    tick;
    chk("bp no extra", ov32, 0);
    // reset with one result at the output and three still in flight
    for (int i = 0; i < 4; i++) begin
      iv32 = 1'b1; a32 = (i == 0) ? 32'hFFFFFFFF : 32'(i); b32 = 32'd1; s32 = 1'b0;
      tick;
    end
    iv32 = 1'b0;
    chk("pre-reset out_valid", ov32, 1);
    chk("pre-reset c/ovf/zero", {c32, f32, z32}, 3'b101);
    #1 reset = 1'b1;
    #1;
    chk("async reset out_valid", ov32, 0);
    chk("async reset out", o32, 0);
    chk("async reset flags", {c32, f32, z32}, 0);
    tick;
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (ov32) stale++;
    end
    chk("no stale results", stale, 0);
    op32("post-reset 5+5", 32'd5, 32'd5, 1'b0, 32'd10, 3'b000);
    // WIDTH=16, CHUNK=4
    iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; s16 = 1'b0;
    tick;
    n = 1;
    iv16 = 1'b0;
    while (!ov16 && n < 20) begin
      tick;
      n++;
    end
    chk("w16 latency", n, 4);
    chk("w16 out", o16, 16'h0000);
    chk("w16 c/ovf/zero", {c16, f16, z16}, 3'b101);
    // WIDTH=8, CHUNK=8
    iv8 = 1'b1; a8 = 8'h80; b8 = 8'h01; s8 = 1'b1;
    tick;
    n = 1;
    iv8 = 1'b0;
    while (!ov8 && n < 20) begin
      tick;
      n++;
    end
    chk("w8 latency", n, 1);
    chk("w8 out", o8, 8'h7F);
    chk("w8 c/ovf/zero", {c8, f8, z8}, 3'b110);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
